// File: rtl/ph_ecc_pipe.sv
// Pipelined, back-pressurable CSI-2 packet-header ECC checker/corrector with
// saturating error counters for link-quality monitoring.
module ph_ecc_pipe #(
  parameter int LATENCY    = 1,
  parameter int CNT_W      = 16,
  parameter bit RSVD_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ph_in,
  input  logic             correct_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      ph_out,
  output logic             no_error,
  output logic             corrected_error,
  output logic             error,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_error
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and once raised valid and its payload
  // hold until the transfer completes.

  typedef struct packed {
    logic [23:0] data;
    logic        no_err;
    logic        corr;
    logic        err;
  } dec_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Parity column contributed by data bit k (CSI-2 v1.x header ECC).
  function automatic logic [5:0] ecc_col(input int k);
    case (k)
      0:       ecc_col = 6'h07;
      1:       ecc_col = 6'h0B;
      2:       ecc_col = 6'h0D;
      3:       ecc_col = 6'h0E;
      4:       ecc_col = 6'h13;
      5:       ecc_col = 6'h15;
      6:       ecc_col = 6'h16;
      7:       ecc_col = 6'h19;
      8:       ecc_col = 6'h1A;
      9:       ecc_col = 6'h1C;
      10:      ecc_col = 6'h23;
      11:      ecc_col = 6'h25;
      12:      ecc_col = 6'h26;
      13:      ecc_col = 6'h29;
      14:      ecc_col = 6'h2A;
      15:      ecc_col = 6'h2C;
      16:      ecc_col = 6'h31;
      17:      ecc_col = 6'h32;
      18:      ecc_col = 6'h34;
      19:      ecc_col = 6'h38;
      20:      ecc_col = 6'h1F;
      21:      ecc_col = 6'h2F;
      22:      ecc_col = 6'h37;
      23:      ecc_col = 6'h3B;
      default: ecc_col = 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p = '0;
    for (int k = 0; k < 24; k++) begin
      if (d[k]) p = p ^ ecc_col(k);
    end
    return p;
  endfunction

  // Classification is mutually exclusive; a reserved-bit violation wins.
  function automatic dec_t decode(input logic [23:0] d, input logic [5:0] syn,
                                  input logic rsvd_bad, input logic fix);
    dec_t        r;
    logic [23:0] hit;
    logic        ecc_bit;
    for (int k = 0; k < 24; k++) begin
      hit[k] = (syn == ecc_col(k));
    end
    ecc_bit  = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
    r.data   = d;
    r.no_err = 1'b0;
    r.corr   = 1'b0;
    r.err    = 1'b0;
    if (rsvd_bad) begin
      r.err = 1'b1;
    end else if (syn == 6'd0) begin
      r.no_err = 1'b1;
    end else if (|hit) begin
      r.corr = 1'b1;
      if (fix) r.data = d ^ hit;
    end else if (ecc_bit) begin
      r.corr = 1'b1;
    end else begin
      r.err = 1'b1;
    end
    return r;
  endfunction

  logic up_valid;
  dec_t up_dec;
  logic out_load;
  logic out_fire;

  assign out_load = !out_valid || out_ready;
  assign out_fire = out_valid && out_ready;

  if (LATENCY >= 2) begin : g_lat2
    logic        s1_valid;
    logic [23:0] s1_data;
    logic [5:0]  s1_syn;
    logic        s1_rsvd_bad;
    logic        s1_fix;

    assign in_ready = !s1_valid || out_load;

    // Syndrome stage: correction is deferred to the output stage.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_valid    <= 1'b0;
        s1_data     <= '0;
        s1_syn      <= '0;
        s1_rsvd_bad <= 1'b0;
        s1_fix      <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data     <= ph_in[23:0];
          s1_syn      <= ph_in[29:24] ^ ecc_calc(ph_in[23:0]);
          s1_rsvd_bad <= RSVD_CHECK && (ph_in[31:30] != 2'b00);
          s1_fix      <= correct_en;
        end
      end
    end

    assign up_valid = s1_valid;
    assign up_dec   = decode(s1_data, s1_syn, s1_rsvd_bad, s1_fix);
  end else begin : g_lat1
    assign in_ready = out_load;
    assign up_valid = in_valid;
    assign up_dec   = decode(ph_in[23:0], ph_in[29:24] ^ ecc_calc(ph_in[23:0]),
                             RSVD_CHECK && (ph_in[31:30] != 2'b00), correct_en);
  end

  // Flags are qualified by valid so they read all-zero on an empty stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      ph_out          <= '0;
      no_error        <= 1'b0;
      corrected_error <= 1'b0;
      error           <= 1'b0;
    end else if (out_load) begin
      out_valid       <= up_valid;
      no_error        <= up_valid && up_dec.no_err;
      corrected_error <= up_valid && up_dec.corr;
      error           <= up_valid && up_dec.err;
      if (up_valid) ph_out <= up_dec.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_corrected <= '0;
      cnt_error     <= '0;
    end else if (cnt_clear) begin
      cnt_corrected <= '0;
      cnt_error     <= '0;
    end else if (out_fire) begin
      if (corrected_error && (cnt_corrected != CNT_MAX))
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (error && (cnt_error != CNT_MAX))
        cnt_error <= cnt_error + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ph_ecc_pipe.sv
// Bench for ph_ecc_pipe: directed header cases plus randomized streams checked
// against a parity-equation reference model, on a LATENCY=1 and a LATENCY=2 copy.
`timescale 1ns/1ps
module tb_ph_ecc_pipe;
  localparam int CW_A = 16;
  localparam int CW_B = 2;

  // Parity equations written as one data mask per ECC bit P0..P5.
  localparam logic [23:0] PMASK [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                        24'hB8E38E, 24'hDF03F0, 24'hEFFC00};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, correct_en, cnt_clear, sel;
  logic [31:0] ph_in;

  logic            a_in_valid, a_in_ready, a_out_valid, a_no, a_corr, a_err;
  logic [23:0]     a_ph_out;
  logic [CW_A-1:0] a_cnt_c, a_cnt_e;
  logic            b_in_valid, b_in_ready, b_out_valid, b_no, b_corr, b_err;
  logic [23:0]     b_ph_out;
  logic [CW_B-1:0] b_cnt_c, b_cnt_e;

  logic        obs_in_ready, obs_out_valid, obs_no, obs_corr, obs_err;
  logic [23:0] obs_ph_out;
  logic [15:0] obs_cnt_c, obs_cnt_e;

  logic [26:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  assign a_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;

  ph_ecc_pipe #(.LATENCY(1), .CNT_W(CW_A), .RSVD_CHECK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ph_in(ph_in), .correct_en(correct_en), .out_valid(a_out_valid),
    .out_ready(out_ready), .ph_out(a_ph_out), .no_error(a_no),
    .corrected_error(a_corr), .error(a_err), .cnt_clear(cnt_clear),
    .cnt_corrected(a_cnt_c), .cnt_error(a_cnt_e));

  ph_ecc_pipe #(.LATENCY(2), .CNT_W(CW_B), .RSVD_CHECK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ph_in(ph_in), .correct_en(correct_en), .out_valid(b_out_valid),
    .out_ready(out_ready), .ph_out(b_ph_out), .no_error(b_no),
    .corrected_error(b_corr), .error(b_err), .cnt_clear(cnt_clear),
    .cnt_corrected(b_cnt_c), .cnt_error(b_cnt_e));

  always_comb begin
    if (sel) begin
      obs_in_ready = b_in_ready; obs_out_valid = b_out_valid; obs_ph_out = b_ph_out;
      obs_no = b_no; obs_corr = b_corr; obs_err = b_err;
      obs_cnt_c = 16'(b_cnt_c); obs_cnt_e = 16'(b_cnt_e);
    end else begin
      obs_in_ready = a_in_ready; obs_out_valid = a_out_valid; obs_ph_out = a_ph_out;
      obs_no = a_no; obs_corr = a_corr; obs_err = a_err;
      obs_cnt_c = a_cnt_c; obs_cnt_e = a_cnt_e;
    end
  end

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish within 500us");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Returns {data[23:0], no_error, corrected_error, error}.
  function automatic logic [26:0] ref_model(input logic [31:0] ph, input logic ce,
                                            input bit rsvd_chk);
    logic [23:0] d, m;
    logic [5:0]  syn, col;
    int          hit;
    d = ph[23:0];
    for (int j = 0; j < 6; j++) begin
      m = PMASK[j];
      syn[j] = ph[24+j] ^ (^(d & m));
    end
    if (rsvd_chk && ph[31:30] != 2'b00) return {d, 3'b001};
    if (syn == 6'd0) return {d, 3'b100};
    hit = -1;
    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < 6; j++) begin
        m = PMASK[j];
        col[j] = m[k];
      end
      if (col == syn) hit = k;
    end
    if (hit >= 0) begin
      if (ce) d[hit] = ~d[hit];
      return {d, 3'b010};
    end
    if ($countones(syn) == 1) return {d, 3'b010};
    return {d, 3'b001};
  endfunction

  function automatic logic [31:0] gen_hdr();
    logic [23:0] d, m;
    logic [5:0]  p;
    logic [1:0]  rsvd;
    int          kind, i0, i1;
    d = 24'($urandom);
    for (int j = 0; j < 6; j++) begin
      m = PMASK[j];
      p[j] = ^(d & m);
    end
    rsvd = 2'b00;
    kind = $urandom_range(0, 5);
    i0 = $urandom_range(0, 23);
    i1 = (i0 + $urandom_range(1, 23)) % 24;
    case (kind)
      1: d[i0] = ~d[i0];
      2: p[i0 % 6] = ~p[i0 % 6];
      3: begin d[i0] = ~d[i0]; d[i1] = ~d[i1]; end
      4: p = 6'($urandom);
      5: rsvd = 2'($urandom_range(1, 3));
      default: ;
    endcase
    return {rsvd, p, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_hdr(input logic [31:0] ph, input logic ce);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1; ph_in = ph; correct_en = ce;
    while (!obs_in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Samples the output after the selected instance's nominal latency.
  task automatic send_and_sample(input logic [31:0] ph, input logic ce,
                                 output logic [26:0] got, output logic got_valid);
    drive_hdr(ph, ce);
    @(negedge clk);
    if (sel) @(negedge clk);
    got = {obs_ph_out, obs_no, obs_corr, obs_err};
    got_valid = obs_out_valid;
  endtask

  task automatic pulse_clear();
    @(negedge clk); cnt_clear = 1'b1;
    @(negedge clk); cnt_clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({a_out_valid, a_ph_out, a_no, a_corr, a_err, b_out_valid, b_ph_out, b_no, b_corr, b_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got a=%0b/%06h/%0b%0b%0b b=%0b/%06h/%0b%0b%0b want all zero",
               a_out_valid, a_ph_out, a_no, a_corr, a_err, b_out_valid, b_ph_out, b_no, b_corr, b_err);
    end
    vectors++;
    if ({a_cnt_c, a_cnt_e, b_cnt_c, b_cnt_e} !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got a=%0d/%0d b=%0d/%0d want 0", a_cnt_c, a_cnt_e, b_cnt_c, b_cnt_e);
    end
    @(negedge clk);
    vectors++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got a=%0b b=%0b want 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_clean();
    logic [26:0] got; logic gv;
    send_and_sample(32'h07000001, 1'b1, got, gv);
    vectors++;
    if (gv !== 1'b1 || got !== {24'h000001, 3'b100}) begin
      miscompares++;
      $display("FAIL clean_hdr: got valid=%0b out=%07h want valid=1 out=%07h", gv, got, {24'h000001, 3'b100});
    end
    @(negedge clk);
    vectors++;
    if (obs_cnt_c !== 16'd0 || obs_cnt_e !== 16'd0 || {obs_out_valid, obs_no, obs_corr, obs_err} !== 4'b0) begin
      miscompares++;
      $display("FAIL clean_after: got cnt=%0d/%0d vf=%0b%0b%0b%0b want 0/0 0000", obs_cnt_c, obs_cnt_e,
               obs_out_valid, obs_no, obs_corr, obs_err);
    end
  endtask

  task automatic test_data_error();
    logic [26:0] got; logic gv;
    send_and_sample(32'h00000001, 1'b1, got, gv);
    vectors++;
    if (gv !== 1'b1 || got !== {24'h000000, 3'b010}) begin
      miscompares++;
      $display("FAIL data_err_fix: got valid=%0b out=%07h want valid=1 out=%07h", gv, got, {24'h000000, 3'b010});
    end
    @(negedge clk);
    vectors++;
    if (obs_cnt_c !== 16'd1) begin
      miscompares++;
      $display("FAIL data_err_cnt1: got %0d want 1", obs_cnt_c);
    end
    send_and_sample(32'h00000001, 1'b0, got, gv);
    vectors++;
    if (gv !== 1'b1 || got !== {24'h000001, 3'b010}) begin
      miscompares++;
      $display("FAIL data_err_raw: got valid=%0b out=%07h want valid=1 out=%07h", gv, got, {24'h000001, 3'b010});
    end
    @(negedge clk);
    vectors++;
    if (obs_cnt_c !== 16'd2) begin
      miscompares++;
      $display("FAIL data_err_cnt2: got %0d want 2", obs_cnt_c);
    end
  endtask

  task automatic test_ecc_error();
    logic [26:0] got; logic gv;
    send_and_sample(32'h01000000, 1'b1, got, gv);
    vectors++;
    if (gv !== 1'b1 || got !== {24'h000000, 3'b010}) begin
      miscompares++;
      $display("FAIL ecc_bit_err: got valid=%0b out=%07h want valid=1 out=%07h", gv, got, {24'h000000, 3'b010});
    end
    @(negedge clk);
    vectors++;
    if (obs_cnt_c !== 16'd3 || obs_cnt_e !== 16'd0) begin
      miscompares++;
      $display("FAIL ecc_bit_cnt: got %0d/%0d want 3/0", obs_cnt_c, obs_cnt_e);
    end
  endtask

  task automatic test_uncorrectable();
    logic [26:0] got; logic gv;
    send_and_sample(32'h00000003, 1'b1, got, gv);
    vectors++;
    if (gv !== 1'b1 || got !== {24'h000003, 3'b001}) begin
      miscompares++;
      $display("FAIL double_err: got valid=%0b out=%07h want valid=1 out=%07h", gv, got, {24'h000003, 3'b001});
    end
    @(negedge clk);
    vectors++;
    if (obs_cnt_e !== 16'd1) begin
      miscompares++;
      $display("FAIL double_err_cnt: got %0d want 1", obs_cnt_e);
    end
    send_and_sample(32'h40000000, 1'b1, got, gv);
    vectors++;
    if (gv !== 1'b1 || got !== {24'h000000, 3'b001}) begin
      miscompares++;
      $display("FAIL rsvd_err: got valid=%0b out=%07h want valid=1 out=%07h", gv, got, {24'h000000, 3'b001});
    end
    @(negedge clk);
    vectors++;
    if (obs_cnt_e !== 16'd2 || obs_cnt_c !== 16'd3) begin
      miscompares++;
      $display("FAIL rsvd_err_cnt: got %0d/%0d want 3/2", obs_cnt_c, obs_cnt_e);
    end
  endtask

  task automatic test_clear_priority();
    logic [26:0] got; logic gv;
    pulse_clear();
    send_and_sample(32'h00000001, 1'b1, got, gv);
    @(negedge clk);
    vectors++;
    if (obs_cnt_c !== 16'd1) begin
      miscompares++;
      $display("FAIL clear_pre_cnt: got %0d want 1", obs_cnt_c);
    end
    out_ready = 1'b0;
    send_and_sample(32'h00000001, 1'b1, got, gv);
    vectors++;
    if (gv !== 1'b1 || got !== {24'h000000, 3'b010}) begin
      miscompares++;
      $display("FAIL clear_held: got valid=%0b out=%07h want valid=1 out=%07h", gv, got, {24'h000000, 3'b010});
    end
    cnt_clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    vectors++;
    if (obs_cnt_c !== 16'd0 || obs_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_priority: got cnt=%0d valid=%0b want cnt=0 valid=0", obs_cnt_c, obs_out_valid);
    end
  endtask

  task automatic test_latency2_rsvd();
    vectors++;
    drive_hdr(32'h40000000, 1'b1);
    @(negedge clk);
    if (obs_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat2_early: got valid=%0b want 0", obs_out_valid);
    end
    @(negedge clk);
    vectors++;
    if (obs_out_valid !== 1'b1 || {obs_ph_out, obs_no, obs_corr, obs_err} !== {24'h000000, 3'b100}) begin
      miscompares++;
      $display("FAIL lat2_rsvd_ignored: got valid=%0b out=%06h/%0b%0b%0b want valid=1 out=000000/100",
               obs_out_valid, obs_ph_out, obs_no, obs_corr, obs_err);
    end
    @(negedge clk);
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random.
  task automatic test_stream(input string name, input int n, input int mode, input bit gaps);
    int rx, cyc, first_cyc, last_cyc, exp_c, exp_e, sat, budget;
    logic [26:0] prev, cur, e;
    logic r;
    bit prev_stall;
    sat = sel ? 3 : 65535;
    budget = n * 8 + 50;
    exp_q.delete();
    pulse_clear();
    exp_c = 0; exp_e = 0; rx = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    prev_stall = 1'b0; prev = '0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [31:0] h;
          logic ce;
          int guard;
          h = gen_hdr();
          ce = 1'($urandom_range(0, 1));
          @(negedge clk); #2;
          if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk); #2;
          end
          in_valid = 1'b1; ph_in = h; correct_en = ce;
          guard = 0;
          while (!obs_in_ready && guard < budget) begin
            @(negedge clk); #2;
            guard++;
          end
          @(posedge clk);
          exp_q.push_back(ref_model(h, ce, !sel));
          #1 in_valid = 1'b0;
        end
      end
      begin
        while (rx < n && cyc < budget) begin
          @(negedge clk);
          cyc++;
          cur = {obs_ph_out, obs_no, obs_corr, obs_err};
          if (prev_stall) begin
            vectors++;
            if (obs_out_valid !== 1'b1 || cur !== prev) begin
              miscompares++;
              $display("FAIL %s_stall_hold: got valid=%0b out=%07h want valid=1 out=%07h", name, obs_out_valid, cur, prev);
            end
          end
          if (!obs_out_valid) begin
            vectors++;
            if ({obs_no, obs_corr, obs_err} !== 3'b000) begin
              miscompares++;
              $display("FAIL %s_idle_flags: got %0b%0b%0b want 000", name, obs_no, obs_corr, obs_err);
            end
          end
          case (mode)
            0: r = 1'b1;
            1: r = ((cyc - 1) % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
          endcase
          out_ready = r;
          if (obs_out_valid && r) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL %s_unexpected: got out=%07h want none", name, cur);
            end else begin
              e = exp_q.pop_front();
              if (cur !== e) begin
                miscompares++;
                $display("FAIL %s_out[%0d]: got %07h want %07h", name, rx, cur, e);
              end
              if (e[1] && exp_c < sat) exp_c++;
              if (e[0] && exp_e < sat) exp_e++;
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            rx++;
          end
          prev_stall = obs_out_valid && !r;
          prev = cur;
        end
        vectors++;
        if (rx != n) begin
          miscompares++;
          $display("FAIL %s_timeout: got %0d outputs want %0d", name, rx, n);
        end
        out_ready = 1'b1;
      end
    join
    @(negedge clk);
    vectors++;
    if (obs_cnt_c !== 16'(exp_c) || obs_cnt_e !== 16'(exp_e)) begin
      miscompares++;
      $display("FAIL %s_counters: got %0d/%0d want %0d/%0d", name, obs_cnt_c, obs_cnt_e, exp_c, exp_e);
    end
    vectors++;
    if (exp_q.size() != 0 || obs_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: got pending=%0d valid=%0b want 0/0", name, exp_q.size(), obs_out_valid);
    end
    if (mode == 0 && !gaps) begin
      vectors++;
      if (last_cyc - first_cyc != n - 1) begin
        miscompares++;
        $display("FAIL %s_throughput: got span %0d want %0d", name, last_cyc - first_cyc, n - 1);
      end
    end
  endtask

  task automatic test_saturation();
    logic [26:0] got; logic gv;
    int want;
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      send_and_sample(32'h00000001, 1'b1, got, gv);
      @(negedge clk);
      want = (i + 1 < 3) ? i + 1 : 3;
      vectors++;
      if (gv !== 1'b1 || obs_cnt_c !== 16'(want)) begin
        miscompares++;
        $display("FAIL sat_cnt[%0d]: got valid=%0b cnt=%0d want valid=1 cnt=%0d", i, gv, obs_cnt_c, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_hdr(32'h07000001, 1'b1);
    drive_hdr(32'h00000003, 1'b1);
    @(negedge clk);
    vectors++;
    if (obs_out_valid !== 1'b1 || obs_ph_out !== 24'h000001) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got valid=%0b out=%06h want valid=1 out=000001", obs_out_valid, obs_ph_out);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({obs_out_valid, obs_ph_out, obs_no, obs_corr, obs_err, obs_cnt_c, obs_cnt_e} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got valid=%0b out=%06h cnt=%0d/%0d want all zero",
               obs_out_valid, obs_ph_out, obs_cnt_c, obs_cnt_e);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_mid_flush[%0d]: got valid=%0b in_ready=%0b want 0/1", i, obs_out_valid, obs_in_ready);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_valid = 1'b0; ph_in = '0; correct_en = 1'b0;
    out_ready = 1'b1; cnt_clear = 1'b0; sel = 1'b0; reset = 1'b1;
    test_reset();
    test_clean();
    test_data_error();
    test_ecc_error();
    test_uncorrectable();
    test_clear_priority();
    test_stream("a_bp", 8, 1, 1'b0);
    test_stream("a_tput", 40, 0, 1'b0);
    test_stream("a_rand", 200, 2, 1'b1);
    sel = 1'b1;
    test_latency2_rsvd();
    test_stream("b_bp", 8, 1, 1'b0);
    test_stream("b_tput", 40, 0, 1'b0);
    test_stream("b_rand", 200, 2, 1'b1);
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
